// File: rtl/keycode_store_pkg.sv
// Shared widths, the default key-word address and named PS/2 scan codes
// for the keycode store slice.
package keycode_store_pkg;

  localparam int KEY_W  = 8;
  localparam int WORD_W = 32;

  // Byte address of the memory-mapped key word (word index 4).
  localparam logic [31:0] DEFAULT_STORE_ADDR = 32'h0000_0010;

  localparam int DEFAULT_MEM_WORDS = 64;

  // Arrow-key make codes the game logic polls for.
  typedef enum logic [KEY_W-1:0] {
    SC_LEFT  = 8'h6B,
    SC_RIGHT = 8'h74,
    SC_UP    = 8'h75,
    SC_DOWN  = 8'h72
  } scan_code_e;

  // Zero-extend a scan code into a full data word.
  function automatic logic [WORD_W-1:0] extend_key(input logic [KEY_W-1:0] code);
    return {{(WORD_W-KEY_W){1'b0}}, code};
  endfunction

endpackage

// File: rtl/keycode_store_if.sv
// Bundle of the PS/2 decoder strobe/data and the CPU-visible key word.
interface keycode_store_if;
  import keycode_store_pkg::*;

  logic [KEY_W-1:0]  key_code;
  logic              data_ready;
  logic [WORD_W-1:0] rd_out;

  // The decoder side drives codes and reads back the stored word.
  modport master (
    output key_code,
    output data_ready,
    input  rd_out
  );

  // The store side samples codes and presents the stored word.
  modport slave (
    input  key_code,
    input  data_ready,
    output rd_out
  );

endinterface

// File: rtl/keycode_store_data_mem.sv
// Generic single-port word RAM: async clear on reset, synchronous write,
// combinational read. Addresses are byte addresses indexed by addr[31:2].
module data_mem
  import keycode_store_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] RAM   [DEPTH];
  logic [WORD_W-1:0] ram_d [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             unused_byte_lanes;

  assign idx               = addr[IDX_W+1:2];
  assign in_range          = (addr[31:2] < 30'(DEPTH));
  assign unused_byte_lanes = ^addr[1:0];

  // Next-state of the array: only the addressed word changes on a write.
  always_comb begin
    ram_d = RAM;
    if (we && in_range) begin
      ram_d[idx] = wdata;
    end
  end

  // Reset wipes every word immediately; otherwise take the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RAM <= '{default: '0};
    end else begin
      RAM <= ram_d;
    end
  end

  assign rdata = in_range ? RAM[idx] : '0;

endmodule

// File: rtl/keycode_store.sv
// Latches the most recent PS/2 scan code into a fixed RAM word and exposes
// that word continuously so software can poll the last key pressed.
module keycode_store
  import keycode_store_pkg::*;
#(
  parameter logic [31:0] STORE_ADDR = DEFAULT_STORE_ADDR,
  parameter int          MEM_WORDS  = DEFAULT_MEM_WORDS
) (
  input logic            clk,
  input logic            rst_n,
  keycode_store_if.slave bus
);

  localparam logic [29:0] STORE_WORD = STORE_ADDR[31:2];

  // A key word outside the RAM would silently never be written.
  if (STORE_WORD >= 30'(MEM_WORDS)) begin : g_bad_store_addr
    $fatal(1, "keycode_store: STORE_ADDR word index exceeds MEM_WORDS");
  end

  logic [WORD_W-1:0] key_word;
  logic [WORD_W-1:0] stored_word;

  assign key_word = extend_key(bus.key_code);

  data_mem #(
    .DEPTH (MEM_WORDS)
  ) data_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.data_ready),
    .addr  (STORE_ADDR),
    .wdata (key_word),
    .rdata (stored_word)
  );

  assign bus.rd_out = stored_word;

endmodule

// File: tb/tb_keycode_store.sv
// Directed self-checking bench for keycode_store.
module tb_keycode_store;
  import keycode_store_pkg::*;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  keycode_store_if kbd ();

  keycode_store dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kbd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation ran past time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic ready);
    kbd.key_code   = code;
    kbd.data_ready = ready;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    applyStimulus(8'h00, 1'b0);

    // Reset held for three cycles
    #2 rst_n = 1'b0;
    repeat (3) step();
    checkOutput("reset_rd_out", kbd.rd_out, 32'h0);
    checkOutput("reset_ram4", dut.data_mem.RAM[4], 32'h0);
    #2 rst_n = 1'b1;
    repeat (2) step();
    checkOutput("post_release", kbd.rd_out, 32'h0);

    // Single key: not visible before the edge, visible right after it
    applyStimulus(8'h6B, 1'b1);
    #1;
    checkOutput("pre_edge_latency", kbd.rd_out, 32'h0);
    step();
    applyStimulus(8'h6B, 1'b0);
    checkOutput("single_rd_out", kbd.rd_out, 32'h0000_006B);
    checkOutput("single_ram4", dut.data_mem.RAM[4], 32'h0000_006B);
    checkOutput("single_ram3", dut.data_mem.RAM[3], 32'h0);
    checkOutput("single_ram5", dut.data_mem.RAM[5], 32'h0);

    // Sequence of pulses two cycles apart
    step();
    applyStimulus(SC_RIGHT, 1'b1);
    step();
    applyStimulus(SC_RIGHT, 1'b0);
    checkOutput("seq_right", kbd.rd_out, 32'h0000_0074);
    step();
    applyStimulus(SC_UP, 1'b1);
    step();
    applyStimulus(SC_UP, 1'b0);
    checkOutput("seq_up", kbd.rd_out, 32'h0000_0075);
    repeat (10) step();
    checkOutput("seq_idle_hold", kbd.rd_out, 32'h0000_0075);

    // Hold: codes change but strobe stays low
    applyStimulus(8'hFF, 1'b0);
    step();
    checkOutput("hold_ff", kbd.rd_out, 32'h0000_0075);
    applyStimulus(8'h00, 1'b0);
    step();
    checkOutput("hold_00", kbd.rd_out, 32'h0000_0075);
    applyStimulus(8'hAA, 1'b0);
    step();
    checkOutput("hold_aa", kbd.rd_out, 32'h0000_0075);

    // Level strobe for three cycles: every sample writes, last one wins
    applyStimulus(8'h11, 1'b1);
    step();
    checkOutput("level_11", kbd.rd_out, 32'h0000_0011);
    applyStimulus(8'h22, 1'b1);
    step();
    checkOutput("level_22", kbd.rd_out, 32'h0000_0022);
    applyStimulus(8'h33, 1'b1);
    step();
    applyStimulus(8'h33, 1'b0);
    checkOutput("level_33", kbd.rd_out, 32'h0000_0033);
    step();
    checkOutput("level_hold", kbd.rd_out, 32'h0000_0033);

    // Break prefix stored like any other code
    applyStimulus(8'hF0, 1'b1);
    step();
    applyStimulus(8'hF0, 1'b0);
    checkOutput("break_prefix", kbd.rd_out, 32'h0000_00F0);

    // Mid-operation async reset between edges
    applyStimulus(SC_UP, 1'b1);
    step();
    applyStimulus(SC_UP, 1'b0);
    checkOutput("pre_reset_store", kbd.rd_out, 32'h0000_0075);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_now", kbd.rd_out, 32'h0);
    #1 rst_n = 1'b1;
    step();
    checkOutput("async_reset_ram4", dut.data_mem.RAM[4], 32'h0);

    // Reset overlapping a strobe edge: reset dominates
    applyStimulus(SC_DOWN, 1'b1);
    #2 rst_n = 1'b0;
    step();
    checkOutput("overlap_reset", kbd.rd_out, 32'h0);
    applyStimulus(SC_DOWN, 1'b0);
    #1 rst_n = 1'b1;
    step();
    checkOutput("overlap_after", kbd.rd_out, 32'h0);

    // A write after reset still works, and only word 4 is touched
    applyStimulus(SC_LEFT, 1'b1);
    step();
    applyStimulus(SC_LEFT, 1'b0);
    checkOutput("post_reset_write", kbd.rd_out, 32'h0000_006B);
    checkOutput("other_ram0", dut.data_mem.RAM[0], 32'h0);
    checkOutput("other_ram63", dut.data_mem.RAM[63], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
